compute_t: RTL



---
 rtl/compute_t.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/compute_t.sv
// Row IDCT stage: T = S' x C over one 8x8 block, two MAC lanes.
// Reads S' from DPRAM0 and writes the 64 T values into DPRAM1.
module compute_t (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        CT_start,
    output logic        CT_done,
    output logic [6:0]  CT_read_address_a,
    output logic [6:0]  CT_read_address_b,
    input  logic [31:0] CT_read_data_a,
    input  logic [31:0] CT_read_data_b,
    output logic [6:0]  CT_write_address,
    output logic [31:0] CT_write_data,
    output logic        CT_write_enable
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Indexed by {f, n}: frequency row f, sample column n.
    localparam logic signed [11:0] W [64] = '{
        12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
        12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
        12'sd2008,  12'sd1702,  12'sd1137,  12'sd399,
        -12'sd399,  -12'sd1137, -12'sd1702, -12'sd2008,
        12'sd1892,  12'sd783,   -12'sd783,  -12'sd1892,
        -12'sd1892, -12'sd783,  12'sd783,   12'sd1892,
        12'sd1702,  -12'sd399,  -12'sd2008, -12'sd1137,
        12'sd1137,  12'sd2008,  12'sd399,   -12'sd1702,
        12'sd1448,  -12'sd1448, -12'sd1448, 12'sd1448,
        12'sd1448,  -12'sd1448, -12'sd1448, 12'sd1448,
        12'sd1137,  -12'sd2008, 12'sd399,   12'sd1702,
        -12'sd1702, -12'sd399,  12'sd2008,  -12'sd1137,
        12'sd783,   -12'sd1892, 12'sd1892,  -12'sd783,
        -12'sd783,  12'sd1892,  -12'sd1892, 12'sd783,
        12'sd399,   -12'sd1137, 12'sd1702,  -12'sd2008,
        12'sd2008,  -12'sd1702, 12'sd1137,  -12'sd399
    };

    state_t state;
    state_t state_nxt;

    logic [7:0] cnt;

    logic       p1_valid;
    logic [1:0] p1_step;
    logic [5:0] p1_elem;
    logic       p2_valid;
    logic [1:0] p2_step;
    logic [5:0] p2_elem;

    logic               m_last;
    logic [5:0]         m_elem;
    logic signed [31:0] acc;

    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [11:0] wa;
    logic signed [11:0] wb;
    logic signed [27:0] sa_x;
    logic signed [27:0] sb_x;
    logic signed [27:0] wa_x;
    logic signed [27:0] wb_x;
    logic signed [27:0] pa;
    logic signed [27:0] pb;
    logic signed [31:0] sum;

    logic unused;
    assign unused = ^{CT_read_data_a[31:16],
                      CT_read_data_b[31:16]};

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        CT_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (CT_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 8'd255) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (CT_write_enable &&
                    CT_write_address == 7'd63) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                CT_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue: cnt = {element j, step s}; j = {row r, column n}.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            cnt               <= 8'd0;
            CT_read_address_a <= 7'd0;
            CT_read_address_b <= 7'd0;
            p1_valid          <= 1'b0;
            p1_step           <= 2'd0;
            p1_elem           <= 6'd0;
            p2_valid          <= 1'b0;
            p2_step           <= 2'd0;
            p2_elem           <= 6'd0;
        end else begin
            p1_valid <= (state == RUN);
            if (state == IDLE && CT_start) begin
                cnt <= 8'd0;
            end else if (state == RUN) begin
                cnt <= cnt + 8'd1;
            end
            if (state == RUN) begin
                CT_read_address_a <= {1'b1, cnt[7:5], cnt[1:0], 1'b0};
                CT_read_address_b <= {1'b1, cnt[7:5], cnt[1:0], 1'b1};
                p1_step           <= cnt[1:0];
                p1_elem           <= cnt[7:2];
            end
            p2_valid <= p1_valid;
            p2_step  <= p1_step;
            p2_elem  <= p1_elem;
        end
    end

    always_comb begin
        sa   = CT_read_data_a[15:0];
        sb   = CT_read_data_b[15:0];
        wa   = W[{p2_step, 1'b0, p2_elem[2:0]}];
        wb   = W[{p2_step, 1'b1, p2_elem[2:0]}];
        sa_x = {{12{sa[15]}}, sa};
        sb_x = {{12{sb[15]}}, sb};
        wa_x = {{16{wa[11]}}, wa};
        wb_x = {{16{wb[11]}}, wb};
        pa   = sa_x * wa_x;
        pb   = sb_x * wb_x;
        sum  = {{4{pa[27]}}, pa} + {{4{pb[27]}}, pb};
    end

    // Step 0 loads the lane sum so no separate clear cycle is needed.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            acc              <= 32'sd0;
            m_last           <= 1'b0;
            m_elem           <= 6'd0;
            CT_write_enable  <= 1'b0;
            CT_write_data    <= 32'd0;
            CT_write_address <= 7'd0;
        end else begin
            m_last <= p2_valid && (p2_step == 2'd3);
            if (p2_valid) begin
                acc    <= (p2_step == 2'd0) ? sum : acc + sum;
                m_elem <= p2_elem;
            end
            CT_write_enable <= m_last;
            if (m_last) begin
                CT_write_data    <= acc >>> 8;
                CT_write_address <= {1'b0, m_elem};
            end
        end
    end

endmodule
